uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_if.sv | 42 ++++
 rtl/uart_tx_fifo.sv | 152 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte-stream bundle between a producer, the TX FIFO and a downstream UART
// transmitter. The slave modport is the FIFO view; master is the user/transmitter
// side (drives writes and the busy line, observes status and the trigger).
interface uart_tx_fifo_if #(
  parameter int AW = 4
) ();

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          uart_trig;
  logic [7:0]    uart_tx_data;
  logic          uart_tx_busy;

  modport slave (
    input  wr_en,
    input  wr_data,
    input  uart_tx_busy,
    output full,
    output empty,
    output count,
    output overflow,
    output uart_trig,
    output uart_tx_data
  );

  modport master (
    output wr_en,
    output wr_data,
    output uart_tx_busy,
    input  full,
    input  empty,
    input  count,
    input  overflow,
    input  uart_trig,
    input  uart_tx_data
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter. Writes are queued in a circular buffer;
// a small launcher FSM pops one byte whenever the transmitter is idle, presents
// it on uart_tx_data and pulses uart_trig for one cycle, then waits for the
// transmitter's busy period (or a short timeout if busy never rises).
module uart_tx_fifo #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int BUSY_TO = 4
) (
  input  logic            clk,
  input  logic            rstn,
  uart_tx_fifo_if.slave   bus
);

  localparam int          TW      = $clog2(BUSY_TO + 1);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TO - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // Storage and pointers
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;

  // Launcher state and registered outputs
  state_t        state_q;
  logic          trig_q;
  logic [7:0]    txd_q;
  logic [TW-1:0] tmr_q;

  logic full_w;
  logic empty_w;
  logic push_w;
  logic pop_w;

  // Flags come straight from the registered occupancy so they never glitch
  // on same-cycle write/pop activity.
  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);

  // A write against a full FIFO is dropped even if a pop frees a slot in the
  // same cycle; the pop only becomes visible to writers on the next cycle.
  assign push_w  = bus.wr_en && !full_w;
  assign pop_w   = (state_q == IDLE) && !empty_w && !bus.uart_tx_busy;

  // Next-state for pointers, occupancy and the sticky overflow flag
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push_w) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_w) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push_w, pop_w})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (bus.wr_en && full_w) begin
      ovf_d = 1'b1;
    end
  end

  // Control registers for the FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Byte storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_w) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  // Launcher FSM: pop in IDLE, pulse trigger in LAUNCH, then track busy
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      trig_q  <= 1'b0;
      txd_q   <= 8'h00;
      tmr_q   <= '0;
    end else begin
      trig_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop_w) begin
            state_q <= LAUNCH;
            trig_q  <= 1'b1;
            txd_q   <= mem_q[rd_ptr_q];
          end
        end
        LAUNCH: begin
          state_q <= WAIT_BUSY;
          tmr_q   <= '0;
        end
        WAIT_BUSY: begin
          // A transmitter that never acknowledges is treated as having sent
          // the byte, so a missing busy cannot stall the queue forever.
          if (bus.uart_tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (tmr_q == TO_LAST) begin
            state_q <= IDLE;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!bus.uart_tx_busy) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.uart_trig    = trig_q;
  assign bus.uart_tx_data = txd_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: reset state, trigger latency, busy timeout,
// burst ordering against a model transmitter, overflow, wrap-around and
// reset in the middle of a burst.
module tb_uart_tx_fifo;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.AW(4)) bus ();

  uart_tx_fifo #(
    .DEPTH   (16),
    .AW      (4),
    .BUSY_TO (4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model transmitter: busy for 20 cycles after each trigger when enabled,
  // otherwise busy follows a manual level.
  logic xmit_en  = 1'b0;
  logic busy_man = 1'b0;
  int   xmit_cnt = 0;

  assign bus.uart_tx_busy = xmit_en ? (xmit_cnt != 0) : busy_man;

  // Transmitter busy countdown
  always @(posedge clk) begin
    if (!xmit_en)           xmit_cnt <= 0;
    else if (bus.uart_trig) xmit_cnt <= 20;
    else if (xmit_cnt > 0)  xmit_cnt <= xmit_cnt - 1;
  end

  // Output monitor: capture every launched byte and any trigger during busy
  logic [7:0] rx_q[$];
  int trig_busy = 0;
  int max_cnt   = 0;

  always @(posedge clk) begin
    if (bus.uart_trig === 1'b1) begin
      rx_q.push_back(bus.uart_tx_data);
      if (bus.uart_tx_busy) trig_busy++;
    end
    if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      $error("%s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_rx(input string tag, input int n, input int limit);
    int k;
    k = 0;
    while (rx_q.size() < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    check(tag, rx_q.size(), n);
  endtask

  // Global time guard
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int seen;
    int k;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;

    // ---------------- reset state ----------------
    rstn = 1'b0;
    tick(3);
    check("rst_count",    bus.count,        0);
    check("rst_empty",    bus.empty,        1);
    check("rst_full",     bus.full,         0);
    check("rst_overflow", bus.overflow,     0);
    check("rst_trig",     bus.uart_trig,    0);
    check("rst_txdata",   bus.uart_tx_data, 8'h00);
    rstn = 1'b1;
    tick(2);

    // ---------------- single byte latency + busy timeout ----------------
    rx_q.delete();
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hA5;
    @(negedge clk);
    bus.wr_en = 1'b0;
    check("lat_n1_trig",  bus.uart_trig, 0);
    check("lat_n1_count", bus.count,     1);
    check("lat_n1_empty", bus.empty,     0);
    @(negedge clk);
    check("lat_n2_trig",  bus.uart_trig,    1);
    check("lat_n2_data",  bus.uart_tx_data, 8'hA5);
    check("lat_n2_count", bus.count,        0);
    check("lat_n2_empty", bus.empty,        1);
    // second byte queued while the launcher waits out the busy timeout
    write_byte(8'h3C);
    check("lat_n3_trig", bus.uart_trig, 0);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.uart_trig) seen++;
    end
    check("to_quiet_trigs", seen, 0);
    check("to_data_hold", bus.uart_tx_data, 8'hA5);
    @(negedge clk);
    check("to_next_trig", bus.uart_trig,    1);
    check("to_next_data", bus.uart_tx_data, 8'h3C);
    tick(10);
    check("single_rx_n", rx_q.size(), 2);

    // ---------------- burst 01..05 with model transmitter ----------------
    rx_q.delete();
    trig_busy = 0;
    xmit_en   = 1'b1;
    for (int i = 1; i <= 5; i++) write_byte(8'(i));
    wait_rx("burst_rx_n", 5, 400);
    for (int i = 0; i < 5; i++) check($sformatf("burst_b%0d", i), rx_q[i], 32'(i + 1));
    check("burst_no_trig_busy", trig_busy, 0);
    tick(30);
    check("burst_count", bus.count, 0);
    check("burst_empty", bus.empty, 1);

    // ---------------- overflow ----------------
    rx_q.delete();
    xmit_en  = 1'b0;
    busy_man = 1'b1;
    tick(2);
    for (int i = 0; i < 17; i++) write_byte(8'(8'h40 + i));
    check("ovf_count",    bus.count,    16);
    check("ovf_full",     bus.full,     1);
    check("ovf_flag",     bus.overflow, 1);
    check("ovf_empty",    bus.empty,    0);
    tick(5);
    check("ovf_no_trig_busy", rx_q.size(), 0);
    busy_man = 1'b0;
    xmit_en  = 1'b1;
    wait_rx("ovf_rx_n", 16, 800);
    tick(60);
    check("ovf_rx_final_n", rx_q.size(), 16);
    for (int i = 0; i < 16; i++) check($sformatf("ovf_b%0d", i), rx_q[i], 32'(8'h40 + i));
    check("ovf_sticky", bus.overflow, 1);
    check("ovf_drained", bus.count, 0);

    // ---------------- reset clears overflow ----------------
    rstn = 1'b0;
    xmit_en = 1'b0;
    @(negedge clk);
    check("rst2_overflow", bus.overflow, 0);
    check("rst2_full",     bus.full,     0);
    rstn = 1'b1;
    tick(2);

    // ---------------- wrap-around stream of 40 bytes ----------------
    rx_q.delete();
    trig_busy = 0;
    max_cnt   = 0;
    xmit_en   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      k = 0;
      while (bus.full && k < 1000) begin
        @(negedge clk);
        k++;
      end
      write_byte(8'(i));
    end
    wait_rx("wrap_rx_n", 40, 2000);
    for (int i = 0; i < 40; i++) check($sformatf("wrap_b%0d", i), rx_q[i], 32'(i));
    check("wrap_max_le16", (max_cnt <= 16), 1);
    check("wrap_max_hit16", max_cnt, 16);
    check("wrap_no_ovf", bus.overflow, 0);
    check("wrap_no_trig_busy", trig_busy, 0);
    tick(30);

    // ---------------- reset mid-burst ----------------
    rx_q.delete();
    xmit_en = 1'b1;
    for (int i = 0; i < 4; i++) write_byte(8'(8'h81 + i));
    tick(3);
    check("mid_count_before", bus.count, 3);
    check("mid_busy_before",  bus.uart_tx_busy, 1);
    rstn     = 1'b0;
    xmit_en  = 1'b0;
    busy_man = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("mid_count",  bus.count,        0);
    check("mid_empty",  bus.empty,        1);
    check("mid_txdata", bus.uart_tx_data, 8'h00);
    check("mid_trig",   bus.uart_trig,    0);
    check("mid_rx_before", rx_q.size(), 1);
    rx_q.delete();
    tick(30);
    check("mid_no_trig_after", rx_q.size(), 0);
    write_byte(8'h77);
    wait_rx("mid_new_rx_n", 1, 20);
    check("mid_new_data", rx_q[0], 8'h77);
    tick(10);
    check("mid_final_count", bus.count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
